// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter: access-size codes (also used by the
// load extender), port-ownership type and small decode helpers.
package dbus_arbiter_pkg;

    localparam logic [2:0] SEL_BYTE = 3'b000;
    localparam logic [2:0] SEL_HALF = 3'b001;
    localparam logic [2:0] SEL_WORD = 3'b010;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    function automatic logic sel_known(input logic [2:0] sel);
        return (sel == SEL_BYTE) || (sel == SEL_HALF) || (sel == SEL_WORD);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] a);
        return ((sel == SEL_HALF) && a[0]) || ((sel == SEL_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundle of CPU, DMA and RAM-side signals around the data-bus arbiter.
// Handshake: a requester holds req and its qualifiers stable until its completion
// strobe (cpu_ready / dma_gnt) is sampled high on a rising clock edge.
interface dbus_arbiter_if #(parameter int ADDR_W = 12);
    logic              cpu_req;
    logic              cpu_we;
    logic [2:0]        cpu_sel;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cpu_addr_exc;

    logic              dma_req;
    logic              dma_we;
    logic [3:0]        dma_be;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_gnt;
    logic [31:0]       dma_rdata;
    logic              dma_rvalid;

    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_sel, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_addr_exc,
        input  dma_req, dma_we, dma_be, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_sel, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_addr_exc,
        output dma_req, dma_we, dma_be, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dbus_store_align.sv
// Sub-word store alignment: byte enables and lane replication from access size and
// the two low address bits. Unknown size codes yield no enabled lanes.
module dbus_store_align
    import dbus_arbiter_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [1:0]  addr_low,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata
);

    always_comb begin
        be         = 4'b0000;
        lane_wdata = wdata;
        case (sel)
            SEL_BYTE: begin
                be         = 4'b0001 << addr_low;
                lane_wdata = {4{wdata[7:0]}};
            end
            SEL_HALF: begin
                be         = addr_low[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
            end
            SEL_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing a single-port, 1-cycle-latency data RAM between the CPU
// MEM stage and a DMA/debug port. Optional macro MISALIGN_EXC_EN flags misaligned CPU accesses.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    dbus_arbiter_if.slave bus,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CPU_RD = 2'd1,
        ST_DMA_RD = 2'd2
    } state_t;

    state_t state, state_n;
    owner_t last_grant, last_grant_n;

    logic [3:0]        cpu_be;
    logic [31:0]       cpu_lane;
    logic [ADDR_W-1:0] cpu_waddr;
    logic              cpu_mis;
    logic              cpu_ok;
    logic              pick_cpu;
    logic              pick_dma;
    logic              unused_addr_hi;

    dbus_store_align u_align (
        .sel        (bus.cpu_sel),
        .addr_low   (bus.cpu_addr[1:0]),
        .wdata      (bus.cpu_wdata),
        .be         (cpu_be),
        .lane_wdata (cpu_lane)
    );

    assign cpu_waddr      = bus.cpu_addr[ADDR_W+1:2];
    assign unused_addr_hi = ^bus.cpu_addr[31:ADDR_W+2];

`ifdef MISALIGN_EXC_EN
    assign cpu_mis = is_misaligned(bus.cpu_sel, bus.cpu_addr[1:0]);
`else
    assign cpu_mis = 1'b0;
`endif

    // Rejected CPU accesses never compete for the RAM; DMA may use it that cycle.
    assign cpu_ok   = sel_known(bus.cpu_sel) && !cpu_mis;
    assign pick_cpu = bus.cpu_req && cpu_ok && (!bus.dma_req || (last_grant == OWN_DMA));
    assign pick_dma = bus.dma_req && !pick_cpu;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= OWN_DMA;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
        end
    end

    always_comb begin
        state_n          = state;
        last_grant_n     = last_grant;
        bus.cpu_rdata    = 32'h0;
        bus.cpu_ready    = 1'b0;
        bus.cpu_addr_exc = 1'b0;
        bus.dma_gnt      = 1'b0;
        bus.dma_rdata    = 32'h0;
        bus.dma_rvalid   = 1'b0;
        bus.ram_en       = 1'b0;
        bus.ram_we       = 4'b0000;
        bus.ram_addr     = '0;
        bus.ram_wdata    = 32'h0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (bus.cpu_req && !cpu_ok) begin
                        bus.cpu_ready    = 1'b1;
                        bus.cpu_addr_exc = cpu_mis;
                    end
                    if (pick_cpu) begin
                        bus.ram_en   = 1'b1;
                        bus.ram_addr = cpu_waddr;
                        last_grant_n = OWN_CPU;
                        if (bus.cpu_we) begin
                            bus.ram_we    = cpu_be;
                            bus.ram_wdata = cpu_lane;
                            bus.cpu_ready = 1'b1;
                        end else begin
                            state_n = ST_CPU_RD;
                        end
                    end else if (pick_dma) begin
                        bus.ram_en    = 1'b1;
                        bus.ram_addr  = bus.dma_addr;
                        bus.ram_wdata = bus.dma_wdata;
                        bus.dma_gnt   = 1'b1;
                        last_grant_n  = OWN_DMA;
                        if (bus.dma_we) begin
                            bus.ram_we = bus.dma_be;
                        end else begin
                            state_n = ST_DMA_RD;
                        end
                    end
                end
                ST_CPU_RD: begin
                    bus.cpu_ready = 1'b1;
                    bus.cpu_rdata = bus.ram_rdata;
                    state_n       = ST_IDLE;
                end
                ST_DMA_RD: begin
                    bus.dma_rvalid = 1'b1;
                    bus.dma_rdata  = bus.ram_rdata;
                    state_n        = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
